// File: rtl/xm23_mem_pkg.sv
// Shared types for the XM23 memory-access stage: FSM state encoding,
// addressing-mode bundle and address step constants.
package xm23_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Decoded addressing-mode bits of one LD/ST/LDR/STR operation.
  typedef struct packed {
    logic pre;
    logic inc;
    logic dec;
    logic rel;
    logic store;
    logic byte_op;
  } amode_t;

  // Step applied by inc/dec: unit step for word-only memories,
  // byte-addressed step sizes when byte lanes are supported.
  localparam int STEP_UNIT   = 1;
  localparam int STEP_WORD_B = 2;
  localparam int STEP_BYTE_B = 1;

endpackage

// File: rtl/mem_addr_gen.sv
// Combinational effective-address and base-update computation.
// Step size depends on MEM_ACCESS_BYTE_EN (byte-addressed steps when defined).
module mem_addr_gen
  import xm23_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 7
) (
  input  amode_t              mode,
  input  logic [DATA_W-1:0]   base,
  input  logic [OFF_W-1:0]    off,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   upd,
  output logic                upd_en
);

  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] off_x;
  logic [ADDR_W-1:0] step_a;
  logic [ADDR_W-1:0] up_a;
  logic [ADDR_W-1:0] dn_a;
  logic [ADDR_W-1:0] upd_a;
  logic              unused_mode;

  // Store/byte bits only matter to the caller (or to step selection).
`ifdef MEM_ACCESS_BYTE_EN
  assign unused_mode = mode.store;
`else
  assign unused_mode = mode.store ^ mode.byte_op;
`endif

  // Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
  always_comb begin
    base_a = base[ADDR_W-1:0];
    off_x  = ADDR_W'($signed(off));
`ifdef MEM_ACCESS_BYTE_EN
    step_a = mode.byte_op ? ADDR_W'(STEP_BYTE_B) : ADDR_W'(STEP_WORD_B);
`else
    step_a = ADDR_W'(STEP_UNIT);
`endif
    up_a   = base_a + step_a;
    dn_a   = base_a - step_a;
    addr   = base_a;
    upd_a  = base_a;
    upd_en = 1'b0;
    if (mode.rel) begin
      addr = base_a + off_x;
    end else if (mode.inc) begin
      // inc wins when both inc and dec are set
      upd_en = 1'b1;
      upd_a  = up_a;
      if (mode.pre) addr = up_a;
    end else if (mode.dec) begin
      upd_en = 1'b1;
      upd_a  = dn_a;
      if (mode.pre) addr = dn_a;
    end
    upd = DATA_W'(upd_a);
  end

endmodule

// File: rtl/mem_access_unit.sv
// XM23 memory-access stage: one LD/ST/LDR/STR at a time, req/ack memory
// transaction, then one-cycle load (wb_*) and base-update (ab_*) pulses.
// Optional byte-lane support is enabled by defining MEM_ACCESS_BYTE_EN.
//
// Handshakes: an op transfers on a clock edge where op_valid && op_ready;
// the source holds the op stable until then. A memory transaction transfers
// on the edge where mem_req && mem_ack; mem_req/mem_addr/mem_we/mem_wdata
// stay stable until that edge, and mem_ack with mem_req low is ignored.
module mem_access_unit
  import xm23_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 7,
  parameter int RIDX_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_store,
  input  logic              op_rel,
  input  logic              op_pre,
  input  logic              op_inc,
  input  logic              op_dec,
`ifdef MEM_ACCESS_BYTE_EN
  input  logic              op_byte,
`endif
  input  logic [DATA_W-1:0] op_base,
  input  logic [RIDX_W-1:0] op_base_idx,
  input  logic [DATA_W-1:0] op_data,
  input  logic [OFF_W-1:0]  op_off,
  input  logic [RIDX_W-1:0] op_dst_idx,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_ACCESS_BYTE_EN
  output logic [1:0]        mem_be,
  output logic              wb_byte,
`endif
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [RIDX_W-1:0] wb_idx,
  output logic [DATA_W-1:0] wb_data,
  output logic              ab_valid,
  output logic [RIDX_W-1:0] ab_idx,
  output logic [DATA_W-1:0] ab_data,
  output logic              stall,
  output logic [1:0]        dbg_state
);

  amode_t            mode_in;
  logic [ADDR_W-1:0] gen_addr;
  logic [DATA_W-1:0] gen_upd;
  logic              gen_upd_en;

  state_e            state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q,  wb_valid_d;
  logic [RIDX_W-1:0] wb_idx_q,    wb_idx_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic              ab_valid_q,  ab_valid_d;
  logic [RIDX_W-1:0] ab_idx_q,    ab_idx_d;
  logic [DATA_W-1:0] ab_data_q,   ab_data_d;
  logic              upd_en_q,    upd_en_d;
`ifdef MEM_ACCESS_BYTE_EN
  logic [1:0]        mem_be_q,    mem_be_d;
  logic              wb_byte_q,   wb_byte_d;
  logic              byte_q,      byte_d;
`endif

  // Bundle the incoming mode bits for the address generator.
  always_comb begin
    mode_in.pre   = op_pre;
    mode_in.inc   = op_inc;
    mode_in.dec   = op_dec;
    mode_in.rel   = op_rel;
    mode_in.store = op_store;
`ifdef MEM_ACCESS_BYTE_EN
    mode_in.byte_op = op_byte;
`else
    mode_in.byte_op = 1'b0;
`endif
  end

  mem_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_addr_gen (
    .mode   (mode_in),
    .base   (op_base),
    .off    (op_off),
    .addr   (gen_addr),
    .upd    (gen_upd),
    .upd_en (gen_upd_en)
  );

  // Next-state and next-output logic for the IDLE -> REQ -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = wb_valid_q;
    wb_idx_d    = wb_idx_q;
    wb_data_d   = wb_data_q;
    ab_valid_d  = ab_valid_q;
    ab_idx_d    = ab_idx_q;
    ab_data_d   = ab_data_q;
    upd_en_d    = upd_en_q;
`ifdef MEM_ACCESS_BYTE_EN
    mem_be_d    = mem_be_q;
    wb_byte_d   = wb_byte_q;
    byte_d      = byte_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = op_store;
          mem_addr_d  = gen_addr;
          mem_wdata_d = op_data;
          wb_idx_d    = op_dst_idx;
          ab_idx_d    = op_base_idx;
          ab_data_d   = gen_upd;
          upd_en_d    = gen_upd_en;
`ifdef MEM_ACCESS_BYTE_EN
          byte_d      = op_byte;
          if (op_byte) begin
            // low byte on both lanes; byte enable picks the lane
            mem_wdata_d = DATA_W'({op_data[7:0], op_data[7:0]});
            mem_be_d    = gen_addr[0] ? 2'b10 : 2'b01;
          end else begin
            mem_be_d    = 2'b11;
          end
`endif
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = ~mem_we_q;
          ab_valid_d = upd_en_q;
          wb_data_d  = mem_rdata;
`ifdef MEM_ACCESS_BYTE_EN
          wb_byte_d  = byte_q & ~mem_we_q;
          if (byte_q) begin
            wb_data_d = DATA_W'(mem_addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0]);
          end
`endif
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        wb_valid_d = 1'b0;
        ab_valid_d = 1'b0;
`ifdef MEM_ACCESS_BYTE_EN
        wb_byte_d  = 1'b0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset abandons any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_idx_q    <= '0;
      wb_data_q   <= '0;
      ab_valid_q  <= 1'b0;
      ab_idx_q    <= '0;
      ab_data_q   <= '0;
      upd_en_q    <= 1'b0;
`ifdef MEM_ACCESS_BYTE_EN
      mem_be_q    <= 2'b00;
      wb_byte_q   <= 1'b0;
      byte_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_idx_q    <= wb_idx_d;
      wb_data_q   <= wb_data_d;
      ab_valid_q  <= ab_valid_d;
      ab_idx_q    <= ab_idx_d;
      ab_data_q   <= ab_data_d;
      upd_en_q    <= upd_en_d;
`ifdef MEM_ACCESS_BYTE_EN
      mem_be_q    <= mem_be_d;
      wb_byte_q   <= wb_byte_d;
      byte_q      <= byte_d;
`endif
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign stall     = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_idx    = wb_idx_q;
  assign wb_data   = wb_data_q;
  assign ab_valid  = ab_valid_q;
  assign ab_idx    = ab_idx_q;
  assign ab_data   = ab_data_q;
`ifdef MEM_ACCESS_BYTE_EN
  assign mem_be    = mem_be_q;
  assign wb_byte   = wb_byte_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues ops and pushes the
// expected memory request and write-back response computed from the
// addressing rules; a responder plays a variable-latency memory; a monitor
// pops and compares whenever the DUT starts a request or delivers a response.
module tb_mem_access_unit;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int OW = 7;
  localparam int RW = 3;
  localparam int REQ_W  = 32 + 2 + 1 + AW + DW;
  localparam int RESP_W = 1 + 1 + RW + DW + 1 + RW + DW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic          op_store = 1'b0, op_rel = 1'b0, op_pre = 1'b0;
  logic          op_inc = 1'b0, op_dec = 1'b0;
  logic [DW-1:0] op_base = '0, op_data = '0;
  logic [RW-1:0] op_base_idx = '0, op_dst_idx = '0;
  logic [OW-1:0] op_off = '0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          wb_valid, ab_valid, stall;
  logic [RW-1:0] wb_idx, ab_idx;
  logic [DW-1:0] wb_data, ab_data;
  logic [1:0]    dbg_state;
  logic [1:0]    be_s;
  logic          wb_byte_s;
`ifdef MEM_ACCESS_BYTE_EN
  logic          op_byte = 1'b0;
  logic [1:0]    mem_be;
  logic          wb_byte;
  assign be_s      = mem_be;
  assign wb_byte_s = wb_byte;
`else
  assign be_s      = 2'b00;
  assign wb_byte_s = 1'b0;
`endif

  logic [REQ_W-1:0]  req_q[$];
  logic [RESP_W-1:0] exp_q[$];
  int                lat_q[$];
  logic [DW-1:0]     rd_q[$];
  int tests = 0, fails = 0, spurious = 0, unstable = 0, cyc = 0;
  logic stray_ack = 1'b0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_store(op_store), .op_rel(op_rel), .op_pre(op_pre), .op_inc(op_inc),
    .op_dec(op_dec),
`ifdef MEM_ACCESS_BYTE_EN
    .op_byte(op_byte),
`endif
    .op_base(op_base), .op_base_idx(op_base_idx), .op_data(op_data),
    .op_off(op_off), .op_dst_idx(op_dst_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_ACCESS_BYTE_EN
    .mem_be(mem_be), .wb_byte(wb_byte),
`endif
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .ab_valid(ab_valid), .ab_idx(ab_idx), .ab_data(ab_data),
    .stall(stall), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver: present one op, hold it until accepted, push expectations
  task automatic issue(input logic st, rel, pre, inc, dec, bt,
                       input logic [15:0] base, data, input logic [6:0] off,
                       input logic [2:0] bidx, didx, input int lat,
                       input logic [15:0] rd, input bit want_resp);
    int step, soff, n;
    logic b, uv;
    logic [15:0] a, u, wexp, wbd;
    logic [1:0] be;
`ifdef MEM_ACCESS_BYTE_EN
    b = bt; step = bt ? 1 : 2;
`else
    b = 1'b0; step = 1; uv = bt;
`endif
    soff = int'(off) - (off[6] ? 128 : 0);
    if (rel) begin
      a = 16'(int'(base) + soff); u = '0; uv = 1'b0;
    end else if (inc || dec) begin
      u = 16'(int'(base) + (inc ? step : -step)); a = pre ? u : base; uv = 1'b1;
    end else begin
      a = base; u = '0; uv = 1'b0;
    end
    wexp = st ? (b ? {data[7:0], data[7:0]} : data) : 16'h0000;
    wbd  = b ? {8'h00, (a[0] ? rd[15:8] : rd[7:0])} : rd;
`ifdef MEM_ACCESS_BYTE_EN
    be = b ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    op_byte = bt;
`else
    be = 2'b00;
`endif
    op_store = st; op_rel = rel; op_pre = pre; op_inc = inc; op_dec = dec;
    op_base = base; op_data = data; op_off = off; op_base_idx = bidx; op_dst_idx = didx;
    op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      check("op_accept_timeout", 1'b0, 1'b1);
      op_valid = 1'b0;
      return;
    end
    req_q.push_back({32'(cyc + 1), be, st, a, wexp});
    if (want_resp)
      exp_q.push_back({!st, !st & b, (st ? 3'b000 : didx), (st ? 16'h0000 : wbd),
                       uv, (uv ? bidx : 3'b000), (uv ? u : 16'h0000), 1'b0, 1'b1});
    lat_q.push_back(lat);
    rd_q.push_back(rd);
    @(negedge clk);
    op_valid = 1'b0;
    op_base = 16'($urandom); op_data = 16'($urandom); op_off = 7'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(op_ready && exp_q.size() == 0 && !mem_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic stray_pulse(input int len);
    @(posedge clk); #2 stray_ack = 1'b1;
    repeat (len) @(posedge clk);
    #2 stray_ack = 1'b0;
    @(negedge clk);
  endtask

  // memory responder: ack after the queued latency; stray acks when idle
  initial begin
    int cnt = 0;
    bit serving = 0;
    logic [15:0] cur_rd = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!serving) begin
          serving = 1;
          if (lat_q.size() == 0) begin
            cnt = 0; cur_rd = 16'($urandom);
          end else begin
            cnt = lat_q.pop_front() - 1; cur_rd = rd_q.pop_front();
          end
        end
        if (cnt == 0) begin
          mem_ack = 1'b1; mem_rdata = cur_rd; serving = 0;
        end else cnt--;
      end else begin
        serving = 0;
        if (stray_ack) begin
          mem_ack = 1'b1; mem_rdata = 16'($urandom);
        end
      end
    end
  end

  // monitor: compare request starts and response cycles against the queues
  initial begin
    logic prev_req = 1'b0, resp_prev = 1'b0, resp_due;
    logic [REQ_W-1:0]  act_req, held;
    logic [RESP_W-1:0] act_resp;
    held = '0;
    forever begin
      @(posedge clk); #1;
      act_req  = {32'(cyc), be_s, mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0000)};
      act_resp = {wb_valid, wb_valid & wb_byte_s, (wb_valid ? wb_idx : 3'b000),
                  (wb_valid ? wb_data : 16'h0000), ab_valid, (ab_valid ? ab_idx : 3'b000),
                  (ab_valid ? ab_data : 16'h0000), op_ready, stall};
      resp_due = prev_req && mem_ack && !rst;
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) check("req_unexpected", act_req, '0);
        else check("mem_request", act_req, req_q.pop_front());
        held = act_req;
      end else if (mem_req && prev_req && act_req[REQ_W-33:0] !== held[REQ_W-33:0]) begin
        unstable++;
      end
      if (resp_prev) check("ready_after_resp", {op_ready, stall}, 2'b10);
      if (resp_due) begin
        if (exp_q.size() == 0) check("resp_unexpected", act_resp, '0);
        else check("writeback", act_resp, exp_q.pop_front());
      end else if (wb_valid || ab_valid) begin
        spurious++;
      end
      resp_prev = resp_due;
      prev_req  = mem_req;
    end
  end

  // stimulus
  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_idx, wb_data,
                          ab_valid, ab_idx, ab_data, stall, op_ready}, 76'd1);
    rst = 1'b0;
    @(negedge clk);

    // LD post-inc, ack on the third request cycle
    issue(0, 0, 0, 1, 0, 0, 16'h1000, 16'h0, 7'h00, 3'd5, 3'd2, 3, 16'hBEEF, 1);
    // ST pre-dec across zero (op_valid held while the LD is outstanding)
    issue(1, 0, 1, 0, 1, 0, 16'h0000, 16'h1234, 7'h00, 3'd1, 3'd0, 1, 16'h5555, 1);
    // LDR with negative and positive offsets
    issue(0, 1, 1, 1, 0, 0, 16'h2000, 16'h0, 7'h7F, 3'd3, 3'd4, 2, 16'h1111, 1);
    issue(0, 1, 0, 0, 1, 0, 16'h2000, 16'h0, 7'h3F, 3'd3, 3'd6, 1, 16'h2222, 1);
    // inc and dec together, and no mode bits at all
    issue(0, 0, 1, 1, 1, 0, 16'hFFFF, 16'h0, 7'h00, 3'd7, 3'd1, 1, 16'h3333, 1);
    issue(1, 0, 0, 0, 0, 0, 16'h4000, 16'hCAFE, 7'h00, 3'd2, 3'd0, 2, 16'h0, 1);
    wait_idle();
    stray_pulse(3);
`ifdef MEM_ACCESS_BYTE_EN
    issue(0, 0, 0, 0, 0, 1, 16'h3001, 16'h0, 7'h00, 3'd1, 3'd3, 1, 16'hAB12, 1);
    issue(0, 0, 0, 1, 0, 0, 16'h3000, 16'h0, 7'h00, 3'd2, 3'd4, 2, 16'h7777, 1);
    issue(1, 0, 0, 0, 0, 1, 16'h3000, 16'h00C5, 7'h00, 3'd1, 3'd0, 1, 16'h0, 1);
`endif

    // reset while in REQ, then a late ack
    wait_idle();
    issue(0, 0, 0, 1, 0, 0, 16'h5000, 16'h0, 7'h00, 3'd1, 3'd1, 20, 16'h9999, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_op", {mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_idx, wb_data,
                           ab_valid, ab_idx, ab_data, stall, op_ready}, 76'd1);
    @(negedge clk); rst = 1'b0;
    stray_pulse(1);
    repeat (3) @(negedge clk);

    // randomized ops, back-to-back with occasional stray acks while idle
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 7'($urandom),
            3'($urandom), 3'($urandom), $urandom_range(1, 4), 16'($urandom), 1);
      if ($urandom_range(0, 5) == 0) begin
        wait_idle();
        stray_pulse($urandom_range(1, 2));
      end
    end
    wait_idle();
    repeat (4) @(negedge clk);
    check("no_spurious_pulses", 32'(spurious), 32'd0);
    check("request_stable", 32'(unstable), 32'd0);
    check("queues_drained", {32'(req_q.size()), 32'(exp_q.size())}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
